lipsi_mem_arbiter: RTL and testbench

Single-port memory arbiter for the shared 512-byte Lipsi memory, holding program and data. Sequences every access and shares the port between two requesters: the Lipsi core (fetch/load/store) and a host loader/debug port (program download, memory inspection). Uses a 4-state FSM with a round-robin tie-break. Sits between lipsi_processor and the synchronous-read memory macro.

---
 rtl/lipsi_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_lipsi_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lipsi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// LipsiMemArbiter (module lipsi_mem_arbiter)
//
// Shares the single port of the 512-byte synchronous-read Lipsi memory between
// the Lipsi core and a host loader/debug port. Every access runs through a
// four-state sequence IDLE -> ACCESS -> DONE -> ACK, so one access takes four
// cycles and the requester sees a one-cycle ack pulse in the ACK cycle.
//
// Ports:
//   clk, reset                    : clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata         : core request; fields stable while req high
//   cpu_ack, cpu_rdata            : core completion pulse and held read data
//   host_req/we/addr/wdata        : host request; fields stable while req high
//   host_ack, host_rdata          : host completion pulse and held read data
//   mem_en/we/addr/wdata          : registered memory command
//   mem_rdata                     : memory read data, valid one cycle after mem_en
//   busy                          : high whenever the sequencer is not in IDLE
//   owner_host                    : 1 when the current/last grant went to the host
//
// Build option:
//   HOST_PRIO_EN : when defined the host wins every tie (core stalls while the
//                  host keeps requesting); otherwise ties alternate round robin.
// -----------------------------------------------------------------------------
module lipsi_mem_arbiter #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner_host
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ACK    = 2'd3
   } state_t;

   state_t            state_q;
   logic              cpuAck_q;
   logic              hostAck_q;
   logic [DATA_W-1:0] cpuRdata_q;
   logic [DATA_W-1:0] hostRdata_q;
   logic              memEn_q;
   logic              memWe_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] memWdata_q;
   logic              isWrite_q;
   logic              busy_q;
   logic              ownerHost_q;

   logic              grantValid_d;
   logic              grantHost_d;

   // Grant decision for the IDLE cycle. A lone requester always wins; a tie
   // goes either to the host unconditionally or to whoever was not served last.
   always_comb begin
      grantValid_d = cpu_req | host_req;
`ifdef HOST_PRIO_EN
      grantHost_d  = host_req;
`else
      if (cpu_req && host_req) begin
         grantHost_d = ~ownerHost_q;
      end else begin
         grantHost_d = host_req;
      end
`endif
   end

   // Access sequencer with all outputs registered. The winner's command is
   // captured only in IDLE, so later changes on the request fields are ignored.
   // The write flag is kept separately because mem_we is cleared after ACCESS
   // but DONE still needs to know whether to load read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cpuAck_q    <= 1'b0;
         hostAck_q   <= 1'b0;
         cpuRdata_q  <= '0;
         hostRdata_q <= '0;
         memEn_q     <= 1'b0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         isWrite_q   <= 1'b0;
         busy_q      <= 1'b0;
         ownerHost_q <= 1'b1;
      end else begin
         cpuAck_q  <= 1'b0;
         hostAck_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grantValid_d) begin
                  state_q     <= ACCESS;
                  busy_q      <= 1'b1;
                  memEn_q     <= 1'b1;
                  ownerHost_q <= grantHost_d;
                  if (grantHost_d) begin
                     memWe_q    <= host_we;
                     isWrite_q  <= host_we;
                     memAddr_q  <= host_addr;
                     memWdata_q <= host_wdata;
                  end else begin
                     memWe_q    <= cpu_we;
                     isWrite_q  <= cpu_we;
                     memAddr_q  <= cpu_addr;
                     memWdata_q <= cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               memEn_q <= 1'b0;
               memWe_q <= 1'b0;
               state_q <= DONE;
            end
            DONE: begin
               // mem_rdata is valid now; only reads update the winner's register
               if (!isWrite_q) begin
                  if (ownerHost_q) begin
                     hostRdata_q <= mem_rdata;
                  end else begin
                     cpuRdata_q <= mem_rdata;
                  end
               end
               hostAck_q <= ownerHost_q;
               cpuAck_q  <= ~ownerHost_q;
               state_q   <= ACK;
            end
            ACK: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cpu_ack    = cpuAck_q;
   assign host_ack   = hostAck_q;
   assign cpu_rdata  = cpuRdata_q;
   assign host_rdata = hostRdata_q;
   assign mem_en     = memEn_q;
   assign mem_we     = memWe_q;
   assign mem_addr   = memAddr_q;
   assign mem_wdata  = memWdata_q;
   assign busy       = busy_q;
   assign owner_host = ownerHost_q;

endmodule

// File: tb/tb_lipsi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for lipsi_mem_arbiter. A behavioural synchronous-read memory sits
// on the mem_* port. Transactions are queued per requester together with the
// read data and ack cycle they must produce; the stimulus task drives the queue
// heads, and each ack pops and compares the head entry.
// -----------------------------------------------------------------------------
module tb_lipsi_mem_arbiter;

   typedef struct packed {
      logic        we;
      logic [8:0]  addr;
      logic [7:0]  wdata;
      logic [7:0]  expRdata;
      logic [15:0] expCycle;
   } txn_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_req, cpu_we, host_req, host_we;
   logic [8:0] cpu_addr, host_addr, mem_addr;
   logic [7:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata;
   logic [7:0] mem_rdata;
   logic       cpu_ack, host_ack, mem_en, mem_we, busy, owner_host;

   logic [7:0] mem [0:511];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   txn_t       cpuQ[$];
   txn_t       hostQ[$];

   lipsi_mem_arbiter #(.ADDR_W(9), .DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner_host(owner_host)
   );

   // Free-running clock
   initial forever #5 clk = ~clk;

   // Cycle counter, sampled on the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   // Preload of the memory contents the directed steps rely on
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h00;
      mem[9'h000] = 8'h11;
      mem[9'h001] = 8'h22;
      mem[9'h002] = 8'h33;
      mem[9'h005] = 8'hA7;
      mem[9'h006] = 8'h6B;
      mem[9'h121] = 8'hD2;
      mem[9'h122] = 8'h4E;
   end

   // Synchronous-read, write-first-free memory macro model
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   // One comparison: counts it, and on mismatch counts and reports the failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic pushTxn(input bit toHost, input logic we, input logic [8:0] addr,
                          input logic [7:0] wdata, input logic [7:0] expRdata,
                          input int expCycle);
      txn_t t;
      t.we       = we;
      t.addr     = addr;
      t.wdata    = wdata;
      t.expRdata = expRdata;
      t.expCycle = 16'(expCycle);
      if (toHost) hostQ.push_back(t);
      else        cpuQ.push_back(t);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " cpu_ack"},    32'(cpu_ack),    32'd0);
      checkOutput({tag, " host_ack"},   32'(host_ack),   32'd0);
      checkOutput({tag, " mem_en"},     32'(mem_en),     32'd0);
      checkOutput({tag, " mem_we"},     32'(mem_we),     32'd0);
      checkOutput({tag, " mem_addr"},   32'(mem_addr),   32'd0);
      checkOutput({tag, " mem_wdata"},  32'(mem_wdata),  32'd0);
      checkOutput({tag, " cpu_rdata"},  32'(cpu_rdata),  32'd0);
      checkOutput({tag, " host_rdata"}, 32'(host_rdata), 32'd0);
      checkOutput({tag, " busy"},       32'(busy),       32'd0);
      checkOutput({tag, " owner_host"}, 32'(owner_host), 32'd1);
   endtask

   // Drives the queued transactions from an IDLE cycle and checks every ack.
   // Runs are continuous, so busy is low exactly on every fourth cycle and
   // mem_en is high exactly one cycle after each IDLE cycle.
   task automatic applyStimulus(input int budget);
      int         t0;
      int         rel;
      logic [8:0] lastAddr;
      logic       lastWe;
      logic [7:0] lastWdata;
      txn_t       t;
      lastAddr  = '0;
      lastWe    = 1'b0;
      lastWdata = '0;
      @(negedge clk);
      t0 = cyc;
      if (cpuQ.size() > 0) begin
         cpu_req = 1'b1; cpu_we = cpuQ[0].we; cpu_addr = cpuQ[0].addr; cpu_wdata = cpuQ[0].wdata;
      end
      if (hostQ.size() > 0) begin
         host_req = 1'b1; host_we = hostQ[0].we; host_addr = hostQ[0].addr; host_wdata = hostQ[0].wdata;
      end
      for (int i = 0; i < budget && (cpuQ.size() + hostQ.size()) > 0; i++) begin
         @(negedge clk);
         rel = cyc - t0;
         checkOutput("busy", 32'(busy), 32'((rel % 4) != 0));
         checkOutput("mem_en", 32'(mem_en), 32'((rel % 4) == 1));
         if (mem_en) begin
            lastAddr = mem_addr; lastWe = mem_we; lastWdata = mem_wdata;
         end
         if (cpuQ.size() == 0) begin
            checkOutput("cpu_ack quiet", 32'(cpu_ack), 32'd0);
         end else if (cpu_ack) begin
            t = cpuQ.pop_front();
            checkOutput("cpu ack cycle", 32'(rel), 32'(t.expCycle));
            checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(t.expRdata));
            checkOutput("cpu mem_addr", 32'(lastAddr), 32'(t.addr));
            checkOutput("cpu mem_we", 32'(lastWe), 32'(t.we));
            if (t.we) checkOutput("cpu mem_wdata", 32'(lastWdata), 32'(t.wdata));
            if (cpuQ.size() > 0) begin
               cpu_we = cpuQ[0].we; cpu_addr = cpuQ[0].addr; cpu_wdata = cpuQ[0].wdata;
            end else begin
               cpu_req = 1'b0; cpu_we = 1'b0;
            end
         end
         if (hostQ.size() == 0) begin
            checkOutput("host_ack quiet", 32'(host_ack), 32'd0);
         end else if (host_ack) begin
            t = hostQ.pop_front();
            checkOutput("host ack cycle", 32'(rel), 32'(t.expCycle));
            checkOutput("host_rdata", 32'(host_rdata), 32'(t.expRdata));
            checkOutput("host mem_addr", 32'(lastAddr), 32'(t.addr));
            checkOutput("host mem_we", 32'(lastWe), 32'(t.we));
            if (t.we) checkOutput("host mem_wdata", 32'(lastWdata), 32'(t.wdata));
            if (hostQ.size() > 0) begin
               host_we = hostQ[0].we; host_addr = hostQ[0].addr; host_wdata = hostQ[0].wdata;
            end else begin
               host_req = 1'b0; host_we = 1'b0;
            end
         end
      end
      checkOutput("queues drained", 32'(cpuQ.size() + hostQ.size()), 32'd0);
      cpuQ.delete();
      hostQ.delete();
      cpu_req  = 1'b0;
      host_req = 1'b0;
      @(negedge clk);
      checkOutput("cpu_ack one-shot", 32'(cpu_ack), 32'd0);
      checkOutput("host_ack one-shot", 32'(host_ack), 32'd0);
      checkOutput("busy after run", 32'(busy), 32'd0);
   endtask

   // Directed sequence
   initial begin
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;

      $display("[TB] core read of 0x005");
      pushTxn(1'b0, 1'b0, 9'h005, 8'h00, 8'hA7, 3);
      applyStimulus(20);

      $display("[TB] host write 0x120, then core read 0x120");
      pushTxn(1'b1, 1'b1, 9'h120, 8'h3C, 8'h00, 3);
      applyStimulus(20);
      pushTxn(1'b0, 1'b0, 9'h120, 8'h00, 8'h3C, 3);
      applyStimulus(20);

      $display("[TB] reset asserted in the DONE cycle of a core read");
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h006;
      @(negedge clk);
      checkOutput("midrst ACCESS mem_en", 32'(mem_en), 32'd1);
      @(negedge clk);
      checkOutput("midrst DONE mem_en", 32'(mem_en), 32'd0);
      checkOutput("midrst DONE busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      checkResetValues("midrst");
      cpu_req = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("midrst no cpu_ack", 32'(cpu_ack), 32'd0);
      end
      reset = 1'b0;
      pushTxn(1'b0, 1'b0, 9'h006, 8'h00, 8'h6B, 3);
      applyStimulus(20);

      $display("[TB] simultaneous requests after reset");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
`ifdef HOST_PRIO_EN
      pushTxn(1'b1, 1'b0, 9'h120, 8'h00, 8'h3C, 3);
      pushTxn(1'b1, 1'b0, 9'h121, 8'h00, 8'hD2, 7);
      pushTxn(1'b1, 1'b0, 9'h122, 8'h00, 8'h4E, 11);
      pushTxn(1'b0, 1'b0, 9'h005, 8'h00, 8'hA7, 15);
      pushTxn(1'b0, 1'b0, 9'h006, 8'h00, 8'h6B, 19);
`else
      pushTxn(1'b0, 1'b0, 9'h005, 8'h00, 8'hA7, 3);
      pushTxn(1'b1, 1'b0, 9'h120, 8'h00, 8'h3C, 7);
      pushTxn(1'b0, 1'b0, 9'h006, 8'h00, 8'h6B, 11);
      pushTxn(1'b1, 1'b0, 9'h121, 8'h00, 8'hD2, 15);
`endif
      applyStimulus(40);

      $display("[TB] back-to-back core reads with req held");
      pushTxn(1'b0, 1'b0, 9'h000, 8'h00, 8'h11, 3);
      pushTxn(1'b0, 1'b0, 9'h001, 8'h00, 8'h22, 7);
      pushTxn(1'b0, 1'b0, 9'h002, 8'h00, 8'h33, 11);
      applyStimulus(30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
